// File: rtl/systolic_sched_if.sv
// Operand stream, per-lane edge handshakes and result port of the systolic job scheduler.
// Signal names are kept from the scheduler's point of view; the slave modport is the scheduler.
interface systolic_sched_if #(
    parameter int unsigned width_p        = 32,
    parameter int unsigned array_width_p  = 2,
    parameter int unsigned array_height_p = 2
);
    logic                                              valid_i;
    logic                                              ready_o;
    logic [width_p-1:0]                                data_i;
    logic [width_p*array_height_p-1:0]                 row_o;
    logic [array_height_p-1:0]                         row_valid_o;
    logic [array_height_p-1:0]                         row_ready_i;
    logic [width_p*array_width_p-1:0]                  col_o;
    logic [array_width_p-1:0]                          col_valid_o;
    logic [array_width_p-1:0]                          col_ready_i;
    logic [width_p*array_height_p*array_width_p-1:0]   z_i;
    logic                                              valid_o;
    logic                                              yumi_i;
    logic [width_p-1:0]                                data_o;

    modport slave (
        input  valid_i, data_i, row_ready_i, col_ready_i, z_i, yumi_i,
        output ready_o, row_o, row_valid_o, col_o, col_valid_o, valid_o, data_o
    );

    modport master (
        output valid_i, data_i, row_ready_i, col_ready_i, z_i, yumi_i,
        input  ready_o, row_o, row_valid_o, col_o, col_valid_o, valid_o, data_o
    );
endinterface

// File: rtl/systolic_sched.sv
// Job scheduler for the systolic array: deserialises operand steps onto the row/column lanes,
// waits for the array to settle, serialises the results and then clears the array.
module systolic_sched #(
    parameter int unsigned width_p        = 32,
    parameter int unsigned array_width_p  = 2,
    parameter int unsigned array_height_p = 2,
    parameter int unsigned depth_p        = 2,
    parameter int unsigned settle_p       = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             flush_i,
    systolic_sched_if.slave  bus,
    output logic             array_reset_o,
    output logic             busy_o
);
    localparam int unsigned H        = array_height_p;
    localparam int unsigned W        = array_width_p;
    localparam int unsigned N        = H + W;
    localparam int unsigned HW       = H * W;
    localparam int unsigned StepW    = $clog2(depth_p + 1);
    localparam int unsigned SlotW    = $clog2(N + 1);
    localparam int unsigned SettleW  = $clog2(settle_p + 1);
    localparam int unsigned IdxW     = $clog2(HW + 1);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StLoad   = 3'd1;
    localparam logic [2:0] StIssue  = 3'd2;
    localparam logic [2:0] StSettle = 3'd3;
    localparam logic [2:0] StDrain  = 3'd4;
    localparam logic [2:0] StClear  = 3'd5;

    logic [2:0]         state_q, state_d;
    logic [StepW-1:0]   step_q, step_d;
    logic [SlotW-1:0]   slot_q, slot_d;
    logic [SettleW-1:0] settle_q, settle_d;
    logic [IdxW-1:0]    idx_q, idx_d;
    logic [H-1:0]       row_v_q, row_v_d;
    logic [W-1:0]       col_v_q, col_v_d;
    logic [width_p-1:0] slot_data_q [N];

    logic in_acc;
    logic out_acc;

    // Flush gates every handshake combinationally so nothing completes in the flush cycle.
    assign bus.ready_o     = ((state_q == StIdle) || (state_q == StLoad)) && !flush_i;
    assign bus.valid_o     = (state_q == StDrain) && !flush_i;
    assign bus.row_valid_o = flush_i ? '0 : row_v_q;
    assign bus.col_valid_o = flush_i ? '0 : col_v_q;

    assign in_acc        = bus.valid_i && bus.ready_o;
    assign out_acc       = bus.valid_o && bus.yumi_i;
    assign array_reset_o = reset_i || (state_q == StClear);
    assign busy_o        = (state_q != StIdle);

    for (genvar r = 0; r < H; r++) begin : g_row
        assign bus.row_o[r*width_p +: width_p] = slot_data_q[r];
    end

    for (genvar c = 0; c < W; c++) begin : g_col
        assign bus.col_o[c*width_p +: width_p] = slot_data_q[H+c];
    end

    always_comb begin
        bus.data_o = '0;
        if (state_q == StDrain) begin
            bus.data_o = bus.z_i[int'(idx_q)*width_p +: width_p];
        end
    end

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        slot_d   = slot_q;
        settle_d = settle_q;
        idx_d    = idx_q;
        row_v_d  = row_v_q & ~(bus.row_valid_o & bus.row_ready_i);
        col_v_d  = col_v_q & ~(bus.col_valid_o & bus.col_ready_i);

        case (state_q)
            StIdle, StLoad: begin
                if (in_acc) begin
                    if (slot_q == SlotW'(N - 1)) begin
                        slot_d  = '0;
                        state_d = StIssue;
                        row_v_d = '1;
                        col_v_d = '1;
                    end else begin
                        slot_d  = slot_q + SlotW'(1);
                        state_d = StLoad;
                    end
                end
            end
            StIssue: begin
                if ((row_v_d == '0) && (col_v_d == '0)) begin
                    if (step_q == StepW'(depth_p - 1)) begin
                        step_d  = '0;
                        state_d = StSettle;
                    end else begin
                        step_d  = step_q + StepW'(1);
                        state_d = StLoad;
                    end
                end
            end
            StSettle: begin
                if (settle_q == SettleW'(settle_p - 1)) begin
                    settle_d = '0;
                    idx_d    = '0;
                    state_d  = StDrain;
                end else begin
                    settle_d = settle_q + SettleW'(1);
                end
            end
            StDrain: begin
                if (out_acc) begin
                    if (idx_q == IdxW'(HW - 1)) begin
                        idx_d   = '0;
                        state_d = StClear;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
            StClear: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Leaving for CLEAR (by flush or completion) always starts the next job from zero.
        if ((flush_i && (state_q != StClear)) || (state_d == StClear) || (state_q == StClear)) begin
            if (state_q != StClear) begin
                state_d = StClear;
            end
            step_d   = '0;
            slot_d   = '0;
            settle_d = '0;
            idx_d    = '0;
            row_v_d  = '0;
            col_v_d  = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= StIdle;
            step_q   <= '0;
            slot_q   <= '0;
            settle_q <= '0;
            idx_q    <= '0;
            row_v_q  <= '0;
            col_v_q  <= '0;
            for (int i = 0; i < int'(N); i++) begin
                slot_data_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            slot_q   <= slot_d;
            settle_q <= settle_d;
            idx_q    <= idx_d;
            row_v_q  <= row_v_d;
            col_v_q  <= col_v_d;
            if (in_acc) begin
                slot_data_q[slot_q] <= bus.data_i;
            end
        end
    end
endmodule

// File: tb/tb_systolic_sched.sv
// Directed job sequence with randomised operands, stalls and lane readies, checked against a
// per-job model of the expected lane words and result order.
module tb_systolic_sched;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 2;
    localparam int unsigned AH = 2;
    localparam int unsigned K  = 2;
    localparam int unsigned S  = 4;
    localparam int unsigned N  = AH + AW;
    localparam int unsigned HW = AH * AW;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    logic array_reset;
    logic busy;

    systolic_sched_if #(.width_p(DW), .array_width_p(AW), .array_height_p(AH)) bus ();

    systolic_sched #(
        .width_p(DW), .array_width_p(AW), .array_height_p(AH), .depth_p(K), .settle_p(S)
    ) dut (
        .clk_i(clk), .reset_i(reset), .flush_i(flush), .bus(bus),
        .array_reset_o(array_reset), .busy_o(busy)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [DW-1:0] words [K*N];
    logic [DW-1:0] zv [HW];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        errors++;
        $error("FAIL %s: cycle budget expired", tag);
    endtask

    task automatic set_job(input bit seq, input bit seqz);
        for (int i = 0; i < int'(K*N); i++) words[i] = seq ? DW'(i + 1) : DW'($urandom);
        for (int i = 0; i < int'(HW); i++) begin
            zv[i] = seqz ? DW'(10 * (i + 1)) : DW'($urandom);
            bus.z_i[i*DW +: DW] = zv[i];
        end
    endtask

    task automatic load_step(input int k, input bit gaps);
        int j = 0;
        int budget = 0;
        while (j < int'(N)) begin
            @(negedge clk);
            bus.valid_i = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.data_i  = bus.valid_i ? words[k*N+j] : DW'($urandom);
            #1;
            chk("load_ready", bus.ready_o, 1);
            chk("load_busy", busy, (k == 0 && j == 0) ? 0 : 1);
            if (bus.valid_i) j++;
            if (++budget > 100) begin
                timeout("load");
                return;
            end
        end
    endtask

    // mode 0: random readies, 1: col lane 1 held off for 5 cycles, 2: all ready, 3: flush
    task automatic issue_step(input int k, input int mode);
        logic [AH-1:0] rpend = '1;
        logic [AW-1:0] cpend = '1;
        int cyc = 0;
        while (rpend != 0 || cpend != 0) begin
            @(negedge clk);
            bus.valid_i = 1'b1;
            bus.data_i  = DW'($urandom);
            if (mode == 0) begin
                bus.row_ready_i = AH'($urandom);
                bus.col_ready_i = AW'($urandom);
            end else if (mode == 1) begin
                bus.row_ready_i = '1;
                bus.col_ready_i = (cyc < 5) ? 2'b01 : 2'b11;
            end else begin
                bus.row_ready_i = '1;
                bus.col_ready_i = '1;
            end
            if (mode == 3) flush = 1'b1;
            #1;
            chk("issue_ready", bus.ready_o, 0);
            chk("issue_valid_o", bus.valid_o, 0);
            if (mode == 3) begin
                chk("flush_row_valid", bus.row_valid_o, 0);
                chk("flush_col_valid", bus.col_valid_o, 0);
                return;
            end
            chk("row_valid", bus.row_valid_o, rpend);
            chk("col_valid", bus.col_valid_o, cpend);
            for (int r = 0; r < int'(AH); r++)
                if (rpend[r]) chk("row_data", bus.row_o[r*DW +: DW], words[k*N+r]);
            for (int c = 0; c < int'(AW); c++)
                if (cpend[c]) chk("col_data", bus.col_o[c*DW +: DW], words[k*N+AH+c]);
            rpend = rpend & ~bus.row_ready_i;
            cpend = cpend & ~bus.col_ready_i;
            if (++cyc > 60) begin
                timeout("issue");
                return;
            end
        end
    endtask

    task automatic settle_phase(input bit stray);
        for (int i = 0; i < int'(S); i++) begin
            @(negedge clk);
            bus.valid_i = 1'b0;
            bus.yumi_i  = stray ? 1'($urandom) : 1'b0;
            #1;
            chk("settle_valid_o", bus.valid_o, 0);
            chk("settle_busy", busy, 1);
            chk("settle_data_o", bus.data_o, 0);
        end
    endtask

    // Drains results up to (not including) index stop_at.
    task automatic drain(input bit gaps, input int stop_at);
        int i = 0;
        int budget = 0;
        while (i < stop_at) begin
            @(negedge clk);
            bus.yumi_i = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            chk("drain_valid_o", bus.valid_o, 1);
            chk("drain_data_o", bus.data_o, zv[i]);
            chk("drain_array_reset", array_reset, 0);
            if (bus.yumi_i) i++;
            if (++budget > 100) begin
                timeout("drain");
                return;
            end
        end
    endtask

    task automatic clear_cycle();
        @(negedge clk);
        flush       = 1'b0;
        bus.yumi_i  = 1'b0;
        bus.valid_i = 1'b0;
        #1;
        chk("clear_array_reset", array_reset, 1);
        chk("clear_busy", busy, 1);
        chk("clear_valid_o", bus.valid_o, 0);
        chk("clear_ready", bus.ready_o, 0);
    endtask

    task automatic job_front(input bit gaps, input int m0, input int m1, input bit stray);
        for (int k = 0; k < int'(K); k++) begin
            load_step(k, gaps);
            issue_step(k, (k == 0) ? m0 : m1);
        end
        settle_phase(stray);
    endtask

    task automatic full_job(input bit gaps, input int m0, input int m1, input bit stray);
        job_front(gaps, m0, m1, stray);
        drain(gaps, HW);
        clear_cycle();
    endtask

    initial begin
        bus.valid_i = 1'b0;
        bus.data_i = '0;
        bus.row_ready_i = '0;
        bus.col_ready_i = '0;
        bus.yumi_i = 1'b0;
        bus.z_i = '0;

        repeat (2) @(negedge clk);
        #1;
        chk("reset_array_reset", array_reset, 1);
        chk("reset_busy", busy, 0);
        chk("reset_valid_o", bus.valid_o, 0);
        chk("reset_data_o", bus.data_o, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_reset_ready", bus.ready_o, 1);
        chk("post_reset_array_reset", array_reset, 0);

        // Basic job, staggered readies, then stalls with stray yumi in settle.
        set_job(1, 1);
        full_job(0, 2, 2, 0);
        full_job(0, 1, 2, 0);
        set_job(0, 1);
        full_job(1, 0, 0, 1);

        // Flush in the first issue cycle, then a fresh 1..8 job.
        set_job(1, 1);
        load_step(0, 0);
        issue_step(0, 3);
        clear_cycle();
        full_job(0, 2, 2, 0);

        // Flush with yumi at drain index 1; the following job drains from index 0.
        set_job(0, 0);
        job_front(0, 0, 0, 0);
        drain(0, 1);
        @(negedge clk);
        flush = 1'b1;
        bus.yumi_i = 1'b1;
        #1;
        chk("flush_drain_valid_o", bus.valid_o, 0);
        clear_cycle();
        set_job(0, 0);
        full_job(1, 0, 0, 1);

        // Reset at drain index 2.
        job_front(0, 2, 2, 0);
        drain(0, 2);
        @(negedge clk);
        reset = 1'b1;
        bus.yumi_i = 1'b1;
        #1;
        chk("mid_reset_array_reset", array_reset, 1);
        @(negedge clk);
        #1;
        chk("after_reset_valid_o", bus.valid_o, 0);
        chk("after_reset_busy", busy, 0);
        chk("after_reset_array_reset", array_reset, 1);
        @(negedge clk);
        reset = 1'b0;
        bus.yumi_i = 1'b0;
        #1;
        chk("release_ready", bus.ready_o, 1);
        chk("release_array_reset", array_reset, 0);

        for (int n = 0; n < 3; n++) begin
            set_job(0, 0);
            full_job(1, 0, 0, 1);
        end

        @(negedge clk);
        #1;
        chk("final_idle_busy", busy, 0);
        chk("final_idle_ready", bus.ready_o, 1);
        chk("final_idle_array_reset", array_reset, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
